// File: rtl/lm70_spi_responder.sv
// Sensor-side responder for a 3-wire LM70-style temperature link.
// It oversamples CS/SCK/SIO on clk, shifts out a 16-bit word and then takes in a 16-bit command.
module lm70_spi_responder #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] ID_WORD     = 16'h800F,
   parameter logic [7:0]  SHDN_CODE   = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs_n,
   input  logic        sck,
   input  logic        sio_in,
   input  logic [15:0] temp_in,
   output logic        sio_out,
   output logic        sio_oe,
   output logic        shutdown,
   output logic        frame_done
);

   localparam int LAST = SYNC_STAGES - 1;

   typedef enum logic [1:0] {IDLE, TX, RX, DONE} state_t;

   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] sio_sync_q, sio_sync_d;
   logic cs_prev_q, cs_prev_d, sck_prev_q, sck_prev_d;
   logic cs_fall_q, cs_fall_d, cs_rise_q, cs_rise_d;
   logic sck_fall_q, sck_fall_d, sck_rise_q, sck_rise_d;
   logic sio_bit_q, sio_bit_d;

   state_t      state_q, state_d;
   logic [15:0] shift_reg_q, shift_reg_d;
   logic [15:0] rx_reg_q, rx_reg_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic        shutdown_q, shutdown_d;
   logic        frame_done_q, frame_done_d;
   logic        sio_oe_q, sio_oe_d;
   logic        sio_out_q, sio_out_d;

   // Edge flags are registered so every pin event lands on the FSM exactly SYNC_STAGES+1 cycles later.
   always_comb begin
      cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
      sio_sync_d = {sio_sync_q[SYNC_STAGES-2:0], sio_in};
      cs_prev_d  = cs_sync_q[LAST];
      sck_prev_d = sck_sync_q[LAST];
      cs_fall_d  = cs_prev_q & ~cs_sync_q[LAST];
      cs_rise_d  = ~cs_prev_q & cs_sync_q[LAST];
      sck_fall_d = sck_prev_q & ~sck_sync_q[LAST];
      sck_rise_d = ~sck_prev_q & sck_sync_q[LAST];
      sio_bit_d  = sio_sync_q[LAST];
   end

   // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync_q    <= '0;
         sck_sync_q   <= '0;
         sio_sync_q   <= '0;
         cs_prev_q    <= 1'b0;
         sck_prev_q   <= 1'b0;
         cs_fall_q    <= 1'b0;
         cs_rise_q    <= 1'b0;
         sck_fall_q   <= 1'b0;
         sck_rise_q   <= 1'b0;
         sio_bit_q    <= 1'b0;
         state_q      <= IDLE;
         shift_reg_q  <= '0;
         rx_reg_q     <= '0;
         bit_cnt_q    <= '0;
         shutdown_q   <= 1'b0;
         frame_done_q <= 1'b0;
         sio_oe_q     <= 1'b0;
         sio_out_q    <= 1'b0;
      end else begin
         cs_sync_q    <= cs_sync_d;
         sck_sync_q   <= sck_sync_d;
         sio_sync_q   <= sio_sync_d;
         cs_prev_q    <= cs_prev_d;
         sck_prev_q   <= sck_prev_d;
         cs_fall_q    <= cs_fall_d;
         cs_rise_q    <= cs_rise_d;
         sck_fall_q   <= sck_fall_d;
         sck_rise_q   <= sck_rise_d;
         sio_bit_q    <= sio_bit_d;
         state_q      <= state_d;
         shift_reg_q  <= shift_reg_d;
         rx_reg_q     <= rx_reg_d;
         bit_cnt_q    <= bit_cnt_d;
         shutdown_q   <= shutdown_d;
         frame_done_q <= frame_done_d;
         sio_oe_q     <= sio_oe_d;
         sio_out_q    <= sio_out_d;
      end
   end

   // NOTE: every signal gets a default first so no latch is inferred on untaken branches.
   always_comb begin
      state_d      = state_q;
      shift_reg_d  = shift_reg_q;
      rx_reg_d     = rx_reg_q;
      bit_cnt_d    = bit_cnt_q;
      shutdown_d   = shutdown_q;
      frame_done_d = 1'b0;
      if (cs_rise_q) begin
         // Deselect wins over a coincident sck edge; a partial command is simply dropped.
         if (state_q != IDLE) begin
            state_d      = IDLE;
            frame_done_d = (state_q == RX) || (state_q == DONE);
         end
      end else begin
         unique case (state_q)
            IDLE: if (cs_fall_q) begin
               shift_reg_d = shutdown_q ? ID_WORD : temp_in;
               bit_cnt_d   = '0;
               state_d     = TX;
            end
            TX: if (sck_fall_q) begin
               shift_reg_d = {shift_reg_q[14:0], 1'b0};
               if (bit_cnt_q == 5'd15) begin
                  bit_cnt_d = '0;
                  state_d   = RX;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
            RX: if (sck_rise_q) begin
               rx_reg_d  = {rx_reg_q[14:0], sio_bit_q};
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd15) begin
                  state_d = DONE;
                  if (rx_reg_d[15:8] == SHDN_CODE)  shutdown_d = 1'b1;
                  else if (rx_reg_d[15:8] == 8'h00) shutdown_d = 1'b0;
               end
            end
            DONE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   // Pad outputs are decoded from the next state so they leave the chip straight from flops.
   always_comb begin
      sio_oe_d  = (state_d == TX);
      sio_out_d = (state_d == TX) ? shift_reg_d[15] : 1'b0;
   end

   assign sio_out    = sio_out_q;
   assign sio_oe     = sio_oe_q;
   assign shutdown   = shutdown_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lm70_spi_responder.sv
// Directed bench for lm70_spi_responder: reads, shutdown commands, aborts, stray edges and reset.
// The initiator runs sck at clk/16 and samples SIO on each sck rise.
module tb_lm70_spi_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs_n = 1'b1;
   logic        sck = 1'b0;
   logic        sio_in = 1'b0;
   logic [15:0] temp_in = '0;
   logic        sio_out, sio_oe, shutdown, frame_done;

   lm70_spi_responder dut (
      .clk        (clk),
      .rst        (rst),
      .cs_n       (cs_n),
      .sck        (sck),
      .sio_in     (sio_in),
      .temp_in    (temp_in),
      .sio_out    (sio_out),
      .sio_oe     (sio_oe),
      .shutdown   (shutdown),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          oe_rise_k, oe_fall_k, shdn_k, done_cnt, done_k, oe_err, stray;
   logic        oe_k3, oe_k4;
   logic [15:0] rd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   // One sck half-period of 8 clks, recording output timing around the interesting edges.
   task automatic wait_phase(input int idx, input bit high);
      logic s0;
      s0 = shutdown;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (!high && idx == 0 && oe_rise_k == 0 && sio_oe) oe_rise_k = k;
         if (!high && idx == 16 && oe_fall_k == 0 && !sio_oe) oe_fall_k = k;
         if (high && idx == 31 && shdn_k == 0 && shutdown !== s0) shdn_k = k;
         if (frame_done) done_cnt++;
      end
   endtask

   task automatic run_frame(input int n, input logic [15:0] cmd);
      oe_rise_k = 0; oe_fall_k = 0; shdn_k = 0; done_cnt = 0; oe_err = 0; rd = '0;
      cs_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         sio_in = (i >= 16 && i < 32) ? cmd[31-i] : 1'b0;
         wait_phase(i, 1'b0);
         if (i < 16) rd = {rd[14:0], sio_out};
         if (sio_oe !== (i < 16)) oe_err++;
         sck = 1'b1;
         wait_phase(i, 1'b1);
         sck = 1'b0;
      end
      wait_phase(n, 1'b0);
   endtask

   task automatic end_frame();
      done_k = 0;
      cs_n = 1'b1;
      sio_in = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (frame_done) begin
            done_cnt++;
            if (done_k == 0) done_k = k;
         end
         if (k == 3) oe_k3 = sio_oe;
         if (k == 4) oe_k4 = sio_oe;
      end
   endtask

   initial begin
      // Reset state
      wait_clks(5);
      check("rst_sio_out", sio_out, 0);
      check("rst_sio_oe", sio_oe, 0);
      check("rst_shutdown", shutdown, 0);
      check("rst_frame_done", frame_done, 0);
      rst = 1'b0;
      wait_clks(10);

      // Temperature read
      temp_in = 16'h0033;
      run_frame(16, 16'h0000);
      check("read_data", rd, 16'h0033);
      check("read_oe_rise_lat", oe_rise_k, 4);
      check("read_oe_fall_lat", oe_fall_k, 4);
      check("read_oe_errs", oe_err, 0);
      end_frame();
      check("read_done_cnt", done_cnt, 1);
      check("read_done_lat", done_k, 4);
      check("read_shutdown", shutdown, 0);

      // Shutdown entry, then ID read
      run_frame(32, 16'hFF00);
      check("shdn_cmd_data", rd, 16'h0033);
      check("shdn_update_lat", shdn_k, 4);
      check("shdn_set", shutdown, 1);
      check("shdn_oe_errs", oe_err, 0);
      end_frame();
      check("shdn_done_cnt", done_cnt, 1);
      temp_in = 16'h1234;
      run_frame(16, 16'h0000);
      check("id_read_data", rd, 16'h800F);
      end_frame();
      check("id_read_shutdown", shutdown, 1);

      // Shutdown exit
      run_frame(32, 16'h00FF);
      check("exit_cmd_data", rd, 16'h800F);
      check("exit_update_lat", shdn_k, 4);
      check("exit_cleared", shutdown, 0);
      end_frame();
      temp_in = 16'h0C80;
      run_frame(16, 16'h0000);
      check("exit_read_data", rd, 16'h0C80);
      end_frame();

      // Abort after 7 TX bits, then a clean read from the MSB
      temp_in = 16'hA5C3;
      run_frame(7, 16'h0000);
      check("abort_tx_bits", rd, 16'h0052);
      end_frame();
      check("abort_tx_oe_k3", oe_k3, 1);
      check("abort_tx_oe_k4", oe_k4, 0);
      check("abort_tx_no_done", done_cnt, 0);
      run_frame(16, 16'h0000);
      check("abort_tx_reread", rd, 16'hA5C3);
      end_frame();

      // Abort after 10 RX bits of a shutdown command
      run_frame(26, 16'hFF00);
      end_frame();
      check("abort_rx_done_cnt", done_cnt, 1);
      check("abort_rx_done_lat", done_k, 4);
      check("abort_rx_shutdown", shutdown, 0);

      // sck toggling with cs_n high must not move any output
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         sck = ~sck;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (sio_oe || sio_out || frame_done || shutdown) stray++;
         end
      end
      check("idle_sck_stray", stray, 0);

      // 40-cycle frame: edges beyond 32 are absorbed, command applied once
      temp_in = 16'h7FFE;
      run_frame(40, 16'hFF00);
      check("long_read_data", rd, 16'h7FFE);
      check("long_oe_errs", oe_err, 0);
      check("long_shutdown", shutdown, 1);
      end_frame();
      check("long_done_cnt", done_cnt, 1);

      // Reset while in shutdown
      rst = 1'b1;
      wait_clks(3);
      check("rst_shdn_cleared", shutdown, 0);
      check("rst_shdn_oe", sio_oe, 0);
      rst = 1'b0;
      wait_clks(12);

      // Reset during TX bit 8 with cs_n held low
      temp_in = 16'h5A5A;
      run_frame(7, 16'h0000);
      sck = 1'b1;
      wait_clks(4);
      check("mid_tx_oe", sio_oe, 1);
      rst = 1'b1;
      wait_clks(3);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_oe", sio_oe, 0);
      check("mid_rst_sio_out", sio_out, 0);
      check("mid_rst_frame_done", frame_done, 0);
      stray = 0;
      for (int i = 0; i < 7; i++) begin
         sck = ~sck;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (sio_oe || frame_done) stray++;
         end
      end
      check("mid_rst_no_drive", stray, 0);
      done_cnt = 0;
      end_frame();
      check("mid_rst_no_done", done_cnt, 0);
      run_frame(16, 16'h0000);
      check("post_rst_read", rd, 16'h5A5A);
      end_frame();
      check("post_rst_done", done_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lm70_spi_responder.md
# lm70_spi_responder

Synthesizable SPI temperature-sensor responder implementing the sensor side of the 3-wire (CS/SCK/SIO) link that the temperature monitor reads. It drives a 16-bit temperature word MSB-first on SIO and accepts an optional 16-bit command word on the same wire, which puts the responder into or out of shutdown. In shutdown it returns a fixed ID word. It runs on the system clock and oversamples the externally driven CS and SCK, so it can stand in for the sensor on-chip or in FPGA loopback builds.

## Interface
- SYNC_STAGES, 2: synchronizer depth for cs_n, sck and sio_in (minimum 2).
- ID_WORD, 16'h800F: word returned while in shutdown.
- SHDN_CODE, 8'hFF: command high byte that enters shutdown. A command high byte of 8'h00 exits shutdown.
- clk  input  1  system clock. All logic is on its rising edge.
- rst  input  1  synchronous reset, active-high.
- cs_n  input  1  chip select from the initiator, active-low, asynchronous to clk.
- sck  input  1  serial clock from the initiator, asynchronous to clk.
- sio_in  input  1  SIO pad input, used during the command phase.
- temp_in  input  16  temperature word presented to the initiator.
- sio_out  output  1  SIO pad output data.
- sio_oe  output  1  SIO pad output enable, 1 = drive.
- shutdown  output  1  shutdown mode flag.
- frame_done  output  1  one-cycle pulse at the end of a valid frame.

## Operation
- Input conditioning:
  - cs_n, sck and sio_in each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last sync stage with one extra flop.
  - On rst, the cs_n chain resets to 0. A frame already in progress at reset is therefore ignored until cs_n is seen high and then low.
  - On rst, the sck chain resets to 0.
- FSM states: IDLE, TX, RX, DONE.
- IDLE:
  - sio_oe=0.
  - On a detected cs_n fall, load shift_reg with ID_WORD if shutdown, otherwise with temp_in. temp_in is sampled in that same cycle.
  - Clear bit_cnt and go to TX.
- TX:
  - sio_oe=1 and sio_out=shift_reg[15].
  - On each detected sck fall: shift_reg <<= 1 and bit_cnt++.
  - After the 16th fall: bit_cnt=0, sio_oe=0, go to RX.
  - sck rises are ignored in TX (the initiator samples on them).
- RX:
  - On each detected sck rise: rx_reg = {rx_reg[14:0], sio_in_sync} and bit_cnt++.
  - After the 16th rise, apply the command and go to DONE:
    - rx_reg[15:8]==SHDN_CODE sets shutdown=1.
    - rx_reg[15:8]==8'h00 clears shutdown.
    - Any other value leaves shutdown unchanged.
- DONE: all sck edges are ignored and sio_oe=0.
- Detected cs_n rise, from any non-IDLE state:
  - Go to IDLE and set sio_oe=0.
  - frame_done pulses for 1 cycle if the state was RX or DONE, i.e. all 16 TX bits were shifted.
  - A partial command (fewer than 16 RX bits) is discarded and shutdown does not change.
- sck edges while in IDLE are ignored.
- bit_cnt is 5 bits wide. There is no wrap: extra edges are absorbed by DONE.
- Simultaneous detected cs_n rise and sck edge in the same cycle: the cs_n rise wins and the sck edge is dropped.
- rst mid-frame: the FSM returns to IDLE, all outputs take their reset values and shutdown is cleared.

## Timing
- Reset values:
  - sio_out=0, sio_oe=0, shutdown=0, frame_done=0, state=IDLE.
  - shift_reg=0, rx_reg=0, bit_cnt=0.
- All outputs are registered.
- Latency from a pin edge to its detection is SYNC_STAGES+1 clk cycles.
- Outputs update 1 cycle after detection. Total pin-to-output latency is SYNC_STAGES+2 cycles (4 at default):
  - cs_n fall to sio_oe=1 and MSB valid.
  - sck fall to next bit valid.
  - 16th sck fall to sio_oe=0.
- shutdown updates SYNC_STAGES+2 cycles after the 32nd sck rise.
- frame_done is asserted SYNC_STAGES+2 cycles after the cs_n rise, for exactly 1 cycle.
- Legal operation requires every sck high phase and low phase to be at least SYNC_STAGES+3 clk cycles.
- Setup before the first sck rise after cs_n falls must also be at least SYNC_STAGES+3 clk cycles.

## Test plan
- Temperature read:
  - Stimulus: temp_in=16'h0033, cs_n low, 16 sck cycles at clk/16, bits sampled on sck rise, then cs_n high.
  - Response: bits read are 16'h0033; sio_oe falls 4 cycles after the 16th fall; frame_done is a single pulse; shutdown=0.
- Shutdown entry and ID read:
  - Stimulus: full 32-bit frame with command 16'hFF00, then a second 16-bit read with temp_in=16'h1234.
  - Response: shutdown=1 after the command; the second read returns 16'h800F.
- Shutdown exit:
  - Stimulus: from shutdown, send command 16'h00FF, then read with temp_in=16'h0C80.
  - Response: shutdown=0 and the read returns 16'h0C80.
- Aborted frames:
  - Stimulus 1: cs_n rises after 7 TX bits. Response: sio_oe=0 within 4 cycles, no frame_done, next read starts from the MSB.
  - Stimulus 2: cs_n rises after 10 RX bits of 16'hFF00. Response: frame_done pulses and shutdown stays 0.
- Edge sensitivity:
  - Stimulus: toggle sck 5 times with cs_n high; separately, run a frame with 40 sck cycles.
  - Response: no output change with cs_n high; in the long frame, edges beyond 32 are ignored and sio_oe stays 0.
- Reset:
  - Stimulus 1: assert rst during TX bit 8 with cs_n held low. Response: outputs reset and no drive until cs_n goes high then low.
  - Stimulus 2: assert rst while in shutdown. Response: shutdown=0.
